// File: rtl/mem_copy_seq.sv
// Memory-to-memory copy sequencer: streams reads from a source macro and replays
// them as writes to a destination macro after a fixed read/pipeline latency.
module mem_copy_seq #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 7,
    parameter int RD_LAT     = 1,
    parameter int PIPE_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   len,
    output logic              rd_ce,
    output logic              rd_we,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_ce,
    output logic              wr_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_mask,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W:0]   words_written
);

    localparam int LAT  = RD_LAT + PIPE_DEPTH;
    // One stage of the total latency is the registered write output itself.
    localparam int DL_N = (LAT > 1) ? (LAT - 1) : 1;

    localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   ONE_L  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
    localparam logic [ADDR_W:0]   ZERO_L = {(ADDR_W+1){1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   src_base_r, dst_base_r;
    logic [ADDR_W:0]     len_r;
    logic [ADDR_W-1:0]   rd_idx_r, rd_idx_s;
    logic                abort_seen_r, abort_seen_s;
    logic                latch_s;

    logic                rd_ce_r, rd_ce_s;
    logic [ADDR_W-1:0]   rd_addr_r, rd_addr_s;
    logic                wr_ce_r, wr_ce_s;
    logic [ADDR_W-1:0]   wr_addr_r, wr_addr_s;
    logic [DATA_W-1:0]   wr_mask_r;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                aborted_r, aborted_s;
    logic [ADDR_W:0]     ww_r, ww_s;

    logic [DL_N-1:0]     dl_v_r;
    logic [ADDR_W-1:0]   dl_i_r [DL_N];
    logic                tap_v_s;
    logic [ADDR_W-1:0]   tap_i_s;
    logic                pending_s;
    logic                last_s;

    assign rd_ce         = rd_ce_r;
    assign rd_we         = 1'b0;
    assign rd_addr       = rd_addr_r;
    assign wr_ce         = wr_ce_r;
    assign wr_we         = wr_ce_r;
    assign wr_addr       = wr_addr_r;
    assign wr_mask       = wr_mask_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign aborted       = aborted_r;
    assign words_written = ww_r;

    // Next-state and next-output decode; outputs are registered from these values.
    always_comb begin
        state_s      = state_r;
        rd_ce_s      = 1'b0;
        rd_idx_s     = rd_idx_r;
        rd_addr_s    = ZERO_A;
        abort_seen_s = abort_seen_r;
        aborted_s    = aborted_r;
        ww_s         = ww_r;
        latch_s      = 1'b0;

        if (LAT > 1) begin
            tap_v_s   = dl_v_r[DL_N-1];
            tap_i_s   = dl_i_r[DL_N-1];
            pending_s = |dl_v_r;
        end else begin
            tap_v_s   = rd_ce_r;
            tap_i_s   = rd_idx_r;
            pending_s = 1'b0;
        end

        last_s = ({1'b0, rd_idx_r} == (len_r - ONE_L));

        case (state_r)
            IDLE: begin
                if (start) begin
                    latch_s      = 1'b1;
                    ww_s         = ZERO_L;
                    aborted_s    = 1'b0;
                    abort_seen_s = 1'b0;
                    if (len != ZERO_L) begin
                        state_s   = RUN;
                        rd_ce_s   = 1'b1;
                        rd_idx_s  = ZERO_A;
                        rd_addr_s = src_base;
                    end else begin
                        state_s = FIN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (abort || last_s) begin
                    state_s = DRAIN;
                    if (abort) begin
                        abort_seen_s = 1'b1;
                    end else begin
                        abort_seen_s = abort_seen_r;
                    end
                end else begin
                    rd_ce_s   = 1'b1;
                    rd_idx_s  = rd_idx_r + ONE_A;
                    rd_addr_s = src_base_r + rd_idx_r + ONE_A;
                end
            end
            DRAIN: begin
                if (pending_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = FIN;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        wr_ce_s = tap_v_s;
        if (tap_v_s) begin
            wr_addr_s = dst_base_r + tap_i_s;
            ww_s      = ww_s + ONE_L;
        end else begin
            wr_addr_s = ZERO_A;
        end

        done_s = (state_s == FIN);
        busy_s = (state_s == RUN) || (state_s == DRAIN);
        if (state_s == FIN) begin
            aborted_s = abort_seen_s;
        end else begin
            aborted_s = aborted_s;
        end
    end

    // State, job parameters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            src_base_r   <= ZERO_A;
            dst_base_r   <= ZERO_A;
            len_r        <= ZERO_L;
            rd_idx_r     <= ZERO_A;
            abort_seen_r <= 1'b0;
            rd_ce_r      <= 1'b0;
            rd_addr_r    <= ZERO_A;
            wr_ce_r      <= 1'b0;
            wr_addr_r    <= ZERO_A;
            wr_mask_r    <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            aborted_r    <= 1'b0;
            ww_r         <= ZERO_L;
        end else begin
            state_r <= state_s;
            if (latch_s) begin
                src_base_r <= src_base;
                dst_base_r <= dst_base;
                len_r      <= len;
            end else begin
                src_base_r <= src_base_r;
                dst_base_r <= dst_base_r;
                len_r      <= len_r;
            end
            rd_idx_r     <= rd_idx_s;
            abort_seen_r <= abort_seen_s;
            rd_ce_r      <= rd_ce_s;
            rd_addr_r    <= rd_addr_s;
            wr_ce_r      <= wr_ce_s;
            wr_addr_r    <= wr_addr_s;
            wr_mask_r    <= wr_ce_s ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            busy_r       <= busy_s;
            done_r       <= done_s;
            aborted_r    <= aborted_s;
            ww_r         <= ww_s;
        end
    end

    // Delay line carrying read-valid and word index toward the write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_v_r <= {DL_N{1'b0}};
            for (int k = 0; k < DL_N; k++) begin
                dl_i_r[k] <= ZERO_A;
            end
        end else begin
            dl_v_r[0] <= rd_ce_r;
            dl_i_r[0] <= rd_idx_r;
            for (int k = 1; k < DL_N; k++) begin
                dl_v_r[k] <= dl_v_r[k-1];
                dl_i_r[k] <= dl_i_r[k-1];
            end
        end
    end

endmodule

// File: tb/tb_mem_copy_seq.sv
// Directed self-checking bench for mem_copy_seq: per-cycle expected outputs are
// derived from each job's parameters (src, dst, len, abort cycle).
module tb_mem_copy_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [5:0] src_base;
    logic [5:0] dst_base;
    logic [6:0] len;
    logic       rd_ce, rd_we, wr_ce, wr_we, busy, done, aborted;
    logic [5:0] rd_addr, wr_addr;
    logic [6:0] wr_mask;
    logic [6:0] words_written;

    int n_cmp = 0;
    int n_err = 0;

    mem_copy_seq dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .src_base(src_base), .dst_base(dst_base), .len(len),
        .rd_ce(rd_ce), .rd_we(rd_we), .rd_addr(rd_addr),
        .wr_ce(wr_ce), .wr_we(wr_we), .wr_addr(wr_addr), .wr_mask(wr_mask),
        .busy(busy), .done(done), .aborted(aborted),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_ce"}, 0, {31'd0, rd_ce}, 32'd0);
        chk({tag, "_rd_addr"}, 0, {26'd0, rd_addr}, 32'd0);
        chk({tag, "_wr_ce"}, 0, {31'd0, wr_ce}, 32'd0);
        chk({tag, "_wr_we"}, 0, {31'd0, wr_we}, 32'd0);
        chk({tag, "_wr_addr"}, 0, {26'd0, wr_addr}, 32'd0);
        chk({tag, "_wr_mask"}, 0, {25'd0, wr_mask}, 32'd0);
        chk({tag, "_busy"}, 0, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, 0, {31'd0, done}, 32'd0);
        chk({tag, "_aborted"}, 0, {31'd0, aborted}, 32'd0);
        chk({tag, "_words"}, 0, {25'd0, words_written}, 32'd0);
    endtask

    // Start is driven in cycle 0; checks cover cycles 1 .. done+1.
    // ab = cycle in which abort is held high (0 = none, must be < ln).
    task automatic run_job(input string tag, input int src, input int dst, input int ln,
                           input int ab, input bit hold);
        int  n, dc;
        bit  abf, re, we;
        int  ea_r, ea_w, eww;
        abf = (ab != 0) && (ab < ln);
        n   = abf ? ab : ln;
        dc  = (n > 0) ? n + 4 : 1;
        src_base = 6'(src);
        dst_base = 6'(dst);
        len      = 7'(ln);
        start    = 1'b1;
        abort    = 1'b0;
        for (int c = 1; c <= dc + 1; c++) begin
            @(posedge clk);
            #1;
            start = hold;
            abort = (c == ab);
            re   = (c <= n);
            we   = (c >= 4) && (c <= n + 3);
            ea_r = re ? (src + c - 1) % 64 : 0;
            ea_w = we ? (dst + c - 4) % 64 : 0;
            eww  = (c < 4) ? 0 : ((c - 3 < n) ? c - 3 : n);
            chk({tag, "_rd_ce"},   c, {31'd0, rd_ce}, {31'd0, re});
            chk({tag, "_rd_we"},   c, {31'd0, rd_we}, 32'd0);
            chk({tag, "_rd_addr"}, c, {26'd0, rd_addr}, ea_r);
            chk({tag, "_wr_ce"},   c, {31'd0, wr_ce}, {31'd0, we});
            chk({tag, "_wr_we"},   c, {31'd0, wr_we}, {31'd0, we});
            chk({tag, "_wr_addr"}, c, {26'd0, wr_addr}, ea_w);
            chk({tag, "_wr_mask"}, c, {25'd0, wr_mask}, we ? 32'h7F : 32'h0);
            chk({tag, "_busy"},    c, {31'd0, busy}, {31'd0, (n > 0) && (c < dc)});
            chk({tag, "_done"},    c, {31'd0, done}, {31'd0, c == dc});
            chk({tag, "_aborted"}, c, {31'd0, aborted}, {31'd0, abf && (c >= dc)});
            chk({tag, "_words"},   c, {25'd0, words_written}, eww);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        src_base = 6'd0;
        dst_base = 6'd0;
        len      = 7'd0;
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_job("basic",  0, 10, 4, 0, 1'b0);
        run_job("wrap",  62, 63, 4, 0, 1'b0);
        run_job("abort",  0,  0, 8, 3, 1'b0);
        run_job("len0",   7,  9, 0, 0, 1'b0);
        run_job("full",   5, 40, 64, 0, 1'b0);
        run_job("single", 33, 2, 1, 0, 1'b0);

        // Abort high while idle must not disturb the next job.
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        run_job("post_idle_abort", 1, 3, 2, 0, 1'b0);

        // Asynchronous reset in cycle 5 of a len=16 job.
        src_base = 6'd0;
        dst_base = 6'd20;
        len      = 7'd16;
        start    = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("pre_reset_rd_ce", 5, {31'd0, rd_ce}, 32'd1);
        chk("pre_reset_wr_ce", 5, {31'd0, wr_ce}, 32'd1);
        reset = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            chk("after_reset_done", c, {31'd0, done}, 32'd0);
            chk("after_reset_wr_ce", c, {31'd0, wr_ce}, 32'd0);
        end
        run_job("fresh", 4, 8, 3, 0, 1'b0);

        // Start held high: second job starts only after FIN returns to IDLE.
        run_job("hold1", 10, 50, 2, 0, 1'b1);
        run_job("hold2", 10, 50, 2, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
